sram_responder64: RTL

- Target side of the 64-bit SRAM-style port that the pipeline core drives (en, 8-bit byte-write-enable, 64-bit byte address, 64-bit wdata/rdata).
- Backs the port with an internal word array and returns read data one cycle after the request.
- Zero-fills the whole array after reset and counts out-of-range accesses.
- One instance sits on each of the instruction and data ports in the simulation/FPGA top.

---
 rtl/sram_responder64.sv | 57 +++++
 1 files changed

// File: rtl/sram_responder64.sv
// sram_responder64: 64-bit SRAM-port target with post-reset zero sweep and out-of-range counter
module sram_responder64 #(
  parameter int AW = 10,
  parameter int OOB_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sram_en,
  input  logic [7:0]           sram_we,
  input  logic [63:0]          sram_addr,
  input  logic [63:0]          sram_wdata,
  output logic [63:0]          sram_rdata,
  output logic                 init_done,
  output logic [OOB_CNT_W-1:0] oob_cnt
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [63:0] mem [2**AW];
  logic [AW-1:0] ptr, idx;
  logic oob, acc, clr_we, oob_hit;
  logic [7:0] mem_we;
  assign idx = sram_addr[AW+2:3];
  assign oob = |sram_addr[63:AW+3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && &ptr) state_nxt = READY;
  end
  always_comb begin
    clr_we = state == CLEAR;
    acc = state == READY && sram_en;
    oob_hit = acc && oob;
    mem_we = (acc && !oob) ? sram_we : 8'h00;
    init_done = state == READY;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      sram_rdata <= '0;
      oob_cnt <= '0;
    end else begin
      if (clr_we) ptr <= ptr + 1'b1;
      if (acc) sram_rdata <= oob ? 64'h0 : mem[idx];
      if (oob_hit && !(&oob_cnt)) oob_cnt <= oob_cnt + 1'b1;
    end
  end
  // The array has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) mem[ptr] <= '0;
    else
      for (int i = 0; i < 8; i++)
        if (mem_we[i]) mem[idx][8*i+:8] <= sram_wdata[8*i+:8];
  end
endmodule
